// File: rtl/usbls_tx_pkt_builder.sv
// Low-speed USB transmit packet builder: turns one token/data/handshake request into a
// byte stream (SYNC, PID, body, CRC) over a valid/ready link to the serializer.
module usbls_tx_pkt_builder #(
    parameter int unsigned MAX_DATA  = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'h80,
    parameter int unsigned LEN_W     = $clog2(MAX_DATA + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_type,
    input  logic [3:0]       req_pid,
    input  logic [6:0]       req_addr,
    input  logic [3:0]       req_endp,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       pl_data,
    input  logic             pl_valid,
    output logic             pl_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] TypeToken = 2'b00;
    localparam logic [1:0] TypeData  = 2'b01;
    localparam logic [1:0] TypeHand  = 2'b10;
    localparam logic [1:0] TypeRsvd  = 2'b11;

    typedef enum logic [2:0] {
        StIdle, StSync, StPid, StTok0, StTok1, StData, StCrcL, StCrcH
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       typ_q, typ_d;
    logic [3:0]       pid_q, pid_d;
    logic [6:0]       addr_q, addr_d;
    logic [3:0]       endp_q, endp_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [15:0]      crc16_q, crc16_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q, tx_last_d;
    logic             err_q, err_d;
    logic             load_en;
    logic             reject;

    // Reflected form of x^5+x^2+1; result lands in the field ready to send LSB first.
    function automatic logic [4:0] crc5_calc(input logic [6:0] a, input logic [3:0] e);
        logic [10:0] bits;
        logic [4:0]  c;
        bits = {e, a};
        c    = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (c[0] ^ bits[i]) c = (c >> 1) ^ 5'h14;
            else                c = c >> 1;
        end
        return ~c;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign load_en   = !tx_valid_q || tx_ready;
    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign reject    = (req_type == TypeRsvd) ||
                       ((req_type == TypeData) && (req_len > LEN_W'(MAX_DATA)));

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign err      = err_q;

    always_comb begin
        state_d    = state_q;
        typ_d      = typ_q;
        pid_d      = pid_q;
        addr_d     = addr_q;
        endp_d     = endp_q;
        cnt_d      = cnt_q;
        crc16_d    = crc16_q;
        tx_data_d  = tx_data_q;
        // An accepted byte leaves the register empty unless a new one loads below.
        tx_valid_d = tx_valid_q && !tx_ready;
        tx_last_d  = load_en ? 1'b0 : tx_last_q;
        err_d      = 1'b0;
        pl_ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        typ_d   = req_type;
                        pid_d   = req_pid;
                        addr_d  = req_addr;
                        endp_d  = req_endp;
                        cnt_d   = req_len;
                        crc16_d = 16'hFFFF;
                        if (load_en) begin
                            tx_data_d  = SYNC_BYTE;
                            tx_valid_d = 1'b1;
                            state_d    = StPid;
                        end else begin
                            state_d = StSync;
                        end
                    end
                end
            end
            StSync: begin
                if (load_en) begin
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = StPid;
                end
            end
            StPid: begin
                if (load_en) begin
                    tx_data_d  = {~pid_q, pid_q};
                    tx_valid_d = 1'b1;
                    if (typ_q == TypeToken) begin
                        state_d = StTok0;
                    end else if (typ_q == TypeData) begin
                        state_d = (cnt_q == '0) ? StCrcL : StData;
                    end else begin
                        tx_last_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            StTok0: begin
                if (load_en) begin
                    tx_data_d  = {endp_q[0], addr_q};
                    tx_valid_d = 1'b1;
                    state_d    = StTok1;
                end
            end
            StTok1: begin
                if (load_en) begin
                    tx_data_d  = {crc5_calc(addr_q, endp_q), endp_q[3:1]};
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b1;
                    state_d    = StIdle;
                end
            end
            StData: begin
                pl_ready = load_en;
                if (load_en && pl_valid) begin
                    tx_data_d  = pl_data;
                    tx_valid_d = 1'b1;
                    crc16_d    = crc16_byte(crc16_q, pl_data);
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) state_d = StCrcL;
                end
            end
            StCrcL: begin
                if (load_en) begin
                    tx_data_d  = ~crc16_q[7:0];
                    tx_valid_d = 1'b1;
                    state_d    = StCrcH;
                end
            end
            StCrcH: begin
                if (load_en) begin
                    tx_data_d  = ~crc16_q[15:8];
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b1;
                    state_d    = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            typ_q      <= TypeHand;
            pid_q      <= '0;
            addr_q     <= '0;
            endp_q     <= '0;
            cnt_q      <= '0;
            crc16_q    <= 16'hFFFF;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            typ_q      <= typ_d;
            pid_q      <= pid_d;
            addr_q     <= addr_d;
            endp_q     <= endp_d;
            cnt_q      <= cnt_d;
            crc16_q    <= crc16_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_usbls_tx_pkt_builder.sv
// Directed bench for usbls_tx_pkt_builder: token, data, zero-length, handshake, backpressure,
// rejects and mid-packet reset, with hand-computed byte sequences.
module tb_usbls_tx_pkt_builder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_type;
    logic [3:0] req_pid;
    logic [6:0] req_addr;
    logic [3:0] req_endp;
    logic [3:0] req_len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic       busy;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pl_q[$];

    usbls_tx_pkt_builder #(
        .MAX_DATA (8),
        .SYNC_BYTE(8'h80)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_type (req_type),
        .req_pid  (req_pid),
        .req_addr (req_addr),
        .req_endp (req_endp),
        .req_len  (req_len),
        .pl_data  (pl_data),
        .pl_valid (pl_valid),
        .pl_ready (pl_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and collects the packet, comparing against exp_q byte by byte.
    task automatic run_pkt(input string name, input logic [1:0] typ, input logic [3:0] pid,
                           input logic [6:0] addr, input logic [3:0] endp,
                           input logic [3:0] len, input bit bp);
        int   idx;
        int   pl_idx;
        int   cyc;
        bit   done;
        bit   stalled;
        logic [7:0] held_data;
        logic held_last;
        idx     = 0;
        pl_idx  = 0;
        cyc     = 0;
        done    = 1'b0;
        stalled = 1'b0;
        held_data = 8'h00;
        held_last = 1'b0;
        req_type  = typ;
        req_pid   = pid;
        req_addr  = addr;
        req_endp  = endp;
        req_len   = len;
        req_valid = 1'b1;
        tx_ready  = 1'b1;
        pl_valid  = 1'b0;
        check({name, "_req_ready"}, req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check({name, "_sync_latency"}, {tx_valid, tx_data}, {1'b1, 8'h80});
        check({name, "_busy"}, {busy, req_ready}, 2'b10);
        while (!done && cyc < 300) begin
            tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            pl_valid = (pl_idx < pl_q.size()) && (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
            pl_data  = (pl_idx < pl_q.size()) ? pl_q[pl_idx] : 8'h00;
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                check({name, "_byte"}, tx_data, exp_q[idx]);
                check({name, "_last"}, tx_last, (idx == exp_q.size() - 1));
                idx++;
                if (idx == exp_q.size()) done = 1'b1;
            end
            if (pl_valid && pl_ready) pl_idx++;
            stalled   = tx_valid && !tx_ready;
            held_data = tx_data;
            held_last = tx_last;
            tick();
            cyc++;
            if (stalled) check({name, "_stall_hold"}, {tx_valid, tx_last, tx_data},
                               {1'b1, held_last, held_data});
        end
        pl_valid = 1'b0;
        tx_ready = 1'b1;
        check({name, "_byte_count"}, idx, exp_q.size());
        check({name, "_pl_consumed"}, pl_idx, pl_q.size());
        if (!bp) check({name, "_cycles"}, cyc, exp_q.size());
        check({name, "_idle_after"}, {busy, req_ready, tx_valid}, 3'b010);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_type  = 2'b00;
        req_pid   = 4'h0;
        req_addr  = 7'h00;
        req_endp  = 4'h0;
        req_len   = 4'h0;
        pl_data   = 8'h00;
        pl_valid  = 1'b0;
        tx_ready  = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {tx_valid, tx_last, pl_ready, err, busy}, 5'b00000);
        check("reset_tx_data", tx_data, 8'h00);
        rst_n = 1'b1;
        tick();
        check("reset_req_ready", req_ready, 1'b1);

        // SETUP addr 0 endp 0
        exp_q = '{8'h80, 8'h2D, 8'h00, 8'h10};
        pl_q  = {};
        run_pkt("token", 2'b00, 4'hD, 7'h00, 4'h0, 4'd0, 1'b0);

        // DATA0, 8-byte setup payload
        exp_q = '{8'h80, 8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00,
                  8'hDD, 8'h94};
        pl_q  = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        run_pkt("data8", 2'b01, 4'h3, 7'h00, 4'h0, 4'd8, 1'b0);

        exp_q = '{8'h80, 8'h4B, 8'h00, 8'h00};
        pl_q  = {};
        run_pkt("data_zero", 2'b01, 4'hB, 7'h00, 4'h0, 4'd0, 1'b0);

        exp_q = '{8'h80, 8'hD2};
        run_pkt("ack", 2'b10, 4'h2, 7'h00, 4'h0, 4'd0, 1'b0);

        exp_q = '{8'h80, 8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00,
                  8'hDD, 8'h94};
        pl_q  = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        for (int r = 0; r < 3; r++) run_pkt("data8_bp", 2'b01, 4'h3, 7'h00, 4'h0, 4'd8, 1'b1);

        // Rejects: oversize length, then reserved type
        for (int r = 0; r < 2; r++) begin
            req_type  = (r == 0) ? 2'b01 : 2'b11;
            req_len   = (r == 0) ? 4'd9 : 4'd0;
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            check("reject_pulse", {err, tx_valid, req_ready, busy}, 4'b1010);
            tick();
            check("reject_clear", {err, tx_valid, req_ready, busy}, 4'b0010);
        end

        // Reset right after the PID byte of a data packet
        req_type  = 2'b01;
        req_pid   = 4'h3;
        req_len   = 4'd8;
        req_valid = 1'b1;
        tx_ready  = 1'b1;
        pl_valid  = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        check("midrst_pid_byte", {tx_valid, tx_data}, {1'b1, 8'hC3});
        rst_n = 1'b0;
        tick();
        check("midrst_abort", {tx_valid, busy}, 2'b00);
        rst_n = 1'b1;
        tick();
        check("midrst_idle", {req_ready, tx_valid}, 2'b10);

        exp_q = '{8'h80, 8'h2D, 8'h00, 8'h10};
        pl_q  = {};
        run_pkt("token_after_rst", 2'b00, 4'hD, 7'h00, 4'h0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
